// File: rtl/alien_gfx_pkg.sv
// Shared types, colours and default bitmaps for the animated alien sprite.
package alien_gfx_pkg;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    EXPLODE = 2'd1,
    DEAD    = 2'd2
  } alien_state_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  // RRRGGGBB colours
  localparam logic [7:0] COL_BODY  = 8'h1A;
  localparam logic [7:0] COL_EYE   = 8'hE0;
  localparam logic [7:0] COL_FLASH = 8'hFC;

  // Native size of the built-in bitmaps
  localparam int unsigned BMP_W = 13;
  localparam int unsigned BMP_H = 10;

  localparam int unsigned ROW_BITS = 4 * BMP_W;

  // One hex nibble per pixel, leftmost nibble is x=0.
  // 0 = transparent, 1 = body, 2 = eye, 3 = explosion flash.
  localparam logic [0:BMP_H-1][ROW_BITS-1:0] FRAME0_BMP = {
    52'h0010000000100,
    52'h0001000001000,
    52'h0011111111100,
    52'h0112111112110,
    52'h1111111111111,
    52'h1011111111101,
    52'h1010000000101,
    52'h0001100011000,
    52'h0000000000000,
    52'h0000000000000
  };

  localparam logic [0:BMP_H-1][ROW_BITS-1:0] FRAME1_BMP = {
    52'h0010000000100,
    52'h1001000001001,
    52'h1011111111101,
    52'h1112111112111,
    52'h1111111111111,
    52'h0111111111110,
    52'h0010000000100,
    52'h0100000000010,
    52'h0000000000000,
    52'h0000000000000
  };

  localparam logic [0:BMP_H-1][ROW_BITS-1:0] EXPLODE_BMP = {
    52'h0000300030000,
    52'h0300030300030,
    52'h0030000000300,
    52'h0003003003000,
    52'h3300033300033,
    52'h0003003003000,
    52'h0030000000300,
    52'h0300030300030,
    52'h0000300030000,
    52'h0000000000000
  };

  // Palette lookup for a bitmap nibble
  function automatic logic [7:0] code_to_rgb(input logic [3:0] code);
    logic [7:0] rgb;
    case (code)
      4'd1:    rgb = COL_BODY;
      4'd2:    rgb = COL_EYE;
      4'd3:    rgb = COL_FLASH;
      default: rgb = TRANSPARENT_ENCODING;
    endcase
    return rgb;
  endfunction

  // Extract the nibble for column x (x=0 is the leftmost pixel)
  function automatic logic [3:0] row_nibble(input logic [ROW_BITS-1:0] row,
                                            input logic [3:0]          x);
    logic [ROW_BITS-1:0] sh;
    sh = row << {x, 2'b00};
    return sh[ROW_BITS-1 -: 4];
  endfunction

endpackage

// File: rtl/alien_frame_rom.sv
// Combinational bitmap lookup: animation frame or explosion, transparent outside the bitmap.
module alien_frame_rom
  import alien_gfx_pkg::*;
#(
  parameter int unsigned WIDTH_X  = 13,
  parameter int unsigned HEIGHT_Y = 10,
  parameter int unsigned FRAME_W  = 1
) (
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic [10:0]        src_x,
  input  logic [10:0]        src_y,
  input  logic               explode,
  output logic [7:0]         rgb
);

  logic                in_range;
  logic [1:0]          fsel;
  logic [3:0]          x_idx;
  logic [3:0]          y_idx;
  logic [ROW_BITS-1:0] row;

  // Select the bitmap row and decode the addressed pixel
  always_comb begin
    rgb      = TRANSPARENT_ENCODING;
    row      = '0;
    fsel     = 2'(frame_sel);
    x_idx    = 4'(src_x);
    y_idx    = 4'(src_y);
    in_range = (src_x < 11'(WIDTH_X))  && (src_x < 11'(BMP_W)) &&
               (src_y < 11'(HEIGHT_Y)) && (src_y < 11'(BMP_H));
    if (in_range) begin
      if (explode) begin
        row = EXPLODE_BMP[y_idx];
      end else begin
        case (fsel)
          2'd1, 2'd3: row = FRAME1_BMP[y_idx];
          default:    row = FRAME0_BMP[y_idx];
        endcase
      end
      rgb = code_to_rgb(row_nibble(row, x_idx));
    end
  end

endmodule

// File: rtl/alien_sprite_anim.sv
// Animated alien sprite: frame animation, hit explosion, dead/revive, registered pixel colour.
module alien_sprite_anim
  import alien_gfx_pkg::*;
#(
  parameter int unsigned WIDTH_X        = 13,
  parameter int unsigned HEIGHT_Y       = 10,
  parameter int unsigned SCALE_SHIFT    = 2,
  parameter int unsigned NUM_FRAMES     = 2,
  parameter int unsigned ANIM_PERIOD    = 30,
  parameter int unsigned EXPLODE_FRAMES = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  input  logic        hit,
  input  logic        revive,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        alive,
  output logic        exploding
);

  localparam int unsigned FRAME_W = (NUM_FRAMES > 1)     ? $clog2(NUM_FRAMES)     : 1;
  localparam int unsigned ANIM_W  = (ANIM_PERIOD > 1)    ? $clog2(ANIM_PERIOD)    : 1;
  localparam int unsigned BOOM_W  = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

  alien_state_t        state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [ANIM_W-1:0]   anim_cnt_q, anim_cnt_d;
  logic [BOOM_W-1:0]   boom_cnt_q, boom_cnt_d;
  logic [7:0]          rgb_q, rgb_d;
  logic                alive_q, alive_d;
  logic                exploding_q, exploding_d;

  logic [10:0]         src_x;
  logic [10:0]         src_y;
  logic [7:0]          rom_rgb;

  assign src_x = offsetX >> SCALE_SHIFT;
  assign src_y = offsetY >> SCALE_SHIFT;

  alien_frame_rom #(
    .WIDTH_X  (WIDTH_X),
    .HEIGHT_Y (HEIGHT_Y),
    .FRAME_W  (FRAME_W)
  ) u_rom (
    .frame_sel (frame_q),
    .src_x     (src_x),
    .src_y     (src_y),
    .explode   (state_q == EXPLODE),
    .rgb       (rom_rgb)
  );

  // Next-state: life cycle FSM, animation and explosion counters, pixel colour
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    anim_cnt_d = anim_cnt_q;
    boom_cnt_d = boom_cnt_q;

    case (state_q)
      ALIVE: begin
        // A hit pre-empts any animation step in the same cycle
        if (hit) begin
          state_d    = EXPLODE;
          boom_cnt_d = BOOM_W'(EXPLODE_FRAMES - 1);
        end else if (startOfFrame) begin
          if (anim_cnt_q == ANIM_W'(ANIM_PERIOD - 1)) begin
            anim_cnt_d = '0;
            frame_d    = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
          end else begin
            anim_cnt_d = anim_cnt_q + ANIM_W'(1);
          end
        end
      end
      EXPLODE: begin
        if (startOfFrame) begin
          if (boom_cnt_q == '0) begin
            state_d = DEAD;
          end else begin
            boom_cnt_d = boom_cnt_q - BOOM_W'(1);
          end
        end
      end
      DEAD: begin
        if (revive) begin
          state_d    = ALIVE;
          frame_d    = '0;
          anim_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ALIVE;
        frame_d    = '0;
        anim_cnt_d = '0;
        boom_cnt_d = '0;
      end
    endcase

    alive_d     = (state_d == ALIVE);
    exploding_d = (state_d == EXPLODE);

    // Pixel colour uses the state registered at sample time
    if (!InsideRectangle || (state_q == DEAD)) begin
      rgb_d = TRANSPARENT_ENCODING;
    end else begin
      rgb_d = rom_rgb;
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ALIVE;
      frame_q     <= '0;
      anim_cnt_q  <= '0;
      boom_cnt_q  <= '0;
      rgb_q       <= TRANSPARENT_ENCODING;
      alive_q     <= 1'b1;
      exploding_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      anim_cnt_q  <= anim_cnt_d;
      boom_cnt_q  <= boom_cnt_d;
      rgb_q       <= rgb_d;
      alive_q     <= alive_d;
      exploding_q <= exploding_d;
    end
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = (rgb_q != TRANSPARENT_ENCODING);
  assign alive          = alive_q;
  assign exploding      = exploding_q;

endmodule

// File: tb/tb_alien_sprite_anim.sv
// Directed self-checking bench for alien_sprite_anim with default parameters.
module tb_alien_sprite_anim;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        hit;
  logic        revive;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        alive;
  logic        exploding;

  int n_cmp;
  int n_err;

  alien_sprite_anim dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .hit             (hit),
    .revive          (revive),
    .drawingRequest  (drawingRequest),
    .RGBout          (RGBout),
    .alive           (alive),
    .exploding       (exploding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic pix(input int x, input int y);
    offsetX = 11'(x);
    offsetY = 11'(y);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetN = 1'b0;
    startOfFrame = 1'b0;
    offsetX = '0;
    offsetY = '0;
    InsideRectangle = 1'b1;
    hit = 1'b0;
    revive = 1'b0;
    #12;
    check_eq("rst_rgb",   32'(RGBout), 32'hFF);
    check_eq("rst_dreq",  32'(drawingRequest), 32'd0);
    check_eq("rst_alive", 32'(alive), 32'd1);
    check_eq("rst_expl",  32'(exploding), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    tick();

    // Scaled pixel lookup, frame 0
    pix(12, 4);
    check_eq("px_3_1",     32'(RGBout), 32'h1A);
    check_eq("px_3_1_dr",  32'(drawingRequest), 32'd1);
    pix(52, 4);
    check_eq("px_x13",     32'(RGBout), 32'hFF);
    check_eq("px_x13_dr",  32'(drawingRequest), 32'd0);
    pix(3, 40);
    check_eq("px_y10",     32'(RGBout), 32'hFF);
    pix(0, 16);
    check_eq("px_0_4",     32'(RGBout), 32'h1A);
    InsideRectangle = 1'b0;
    pix(12, 4);
    check_eq("px_outside", 32'(RGBout), 32'hFF);
    InsideRectangle = 1'b1;

    // Animation: pixel (0,1) is transparent in frame 0, body in frame 1
    sof(29);
    pix(3, 7);
    check_eq("anim_29",  32'(RGBout), 32'hFF);
    sof(1);
    pix(0, 4);
    check_eq("anim_30",  32'(RGBout), 32'h1A);
    sof(29);
    pix(0, 4);
    check_eq("anim_59",  32'(RGBout), 32'h1A);
    sof(1);
    pix(0, 4);
    check_eq("anim_60",  32'(RGBout), 32'hFF);

    // Reset in the middle of an explosion
    sof(30);
    pix(0, 4);
    check_eq("pre_rst_f1", 32'(RGBout), 32'h1A);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    check_eq("pre_rst_expl", 32'(exploding), 32'd1);
    pix(0, 16);
    check_eq("pre_rst_boom", 32'(RGBout), 32'hFC);
    #2;
    resetN = 1'b0;
    #1;
    check_eq("mid_rst_rgb",   32'(RGBout), 32'hFF);
    check_eq("mid_rst_alive", 32'(alive), 32'd1);
    check_eq("mid_rst_expl",  32'(exploding), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    pix(0, 4);
    check_eq("post_rst_f0",  32'(RGBout), 32'hFF);
    pix(0, 16);
    check_eq("post_rst_px",  32'(RGBout), 32'h1A);

    // hit and startOfFrame together at animCnt=29: hit wins
    sof(29);
    hit = 1'b1;
    startOfFrame = 1'b1;
    tick();
    hit = 1'b0;
    startOfFrame = 1'b0;
    check_eq("coll_expl",  32'(exploding), 32'd1);
    check_eq("coll_alive", 32'(alive), 32'd0);
    pix(0, 16);
    check_eq("boom_px",    32'(RGBout), 32'hFC);
    pix(12, 4);
    check_eq("boom_px_hole", 32'(RGBout), 32'hFF);

    // revive during explosion is ignored
    revive = 1'b1;
    tick();
    revive = 1'b0;
    check_eq("rev_in_expl", 32'(exploding), 32'd1);

    sof(15);
    check_eq("boom_15", 32'(exploding), 32'd1);
    sof(1);
    check_eq("dead_expl",  32'(exploding), 32'd0);
    check_eq("dead_alive", 32'(alive), 32'd0);
    pix(0, 16);
    check_eq("dead_px",    32'(RGBout), 32'hFF);
    check_eq("dead_dr",    32'(drawingRequest), 32'd0);

    // Extra hit while dead is ignored
    hit = 1'b1;
    tick();
    hit = 1'b0;
    check_eq("dead_hit_expl", 32'(exploding), 32'd0);
    pix(12, 4);
    check_eq("dead_hit_px",   32'(RGBout), 32'hFF);

    // revive with startOfFrame: counters restart at 0, no advance
    revive = 1'b1;
    startOfFrame = 1'b1;
    tick();
    revive = 1'b0;
    startOfFrame = 1'b0;
    check_eq("rev_alive", 32'(alive), 32'd1);
    pix(12, 4);
    check_eq("rev_px",    32'(RGBout), 32'h1A);
    pix(0, 4);
    check_eq("rev_f0",    32'(RGBout), 32'hFF);
    sof(29);
    pix(0, 4);
    check_eq("rev_anim_29", 32'(RGBout), 32'hFF);
    sof(1);
    pix(0, 4);
    check_eq("rev_anim_30", 32'(RGBout), 32'h1A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
